// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time trial controller.
package reaction_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StDelay  = 3'd1,
        StStim   = 3'd2,
        StResult = 3'd3,
        StFault  = 3'd4
    } state_e;

    localparam logic [15:0] BCD_MAX     = 16'h9999;
    localparam logic [15:0] FAULT_CODE  = 16'hEEEE;
    // Fibonacci taps 16,14,13,11 as a mask over state bits [15:0]
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam int unsigned SYNC_STAGES = 2;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous active-high reset to SEED.
module lfsr16
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [15:0] o_state
);

    logic [15:0] r_state;
    logic        w_fb;

    assign w_fb = ^(r_state & LFSR_TAPS);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= {r_state[14:0], w_fb};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/reaction_controller.sv
// Reaction-time trial sequencer: start -> random wait -> stimulus -> ms count -> held result.
// Drives the four-digit BCD display path; flags false starts and saturated (timeout) results.
module reaction_controller
    import reaction_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 100000000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned DELAY_BITS   = 11,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        ck_rst,
    input  logic        btn_start,
    input  logic        btn_react,
    output logic        stim_led,
    output logic [15:0] bcd_digits,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout,
    output logic        busy
);

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DLY_W    = $clog2(MIN_DELAY_MS + (1 << DELAY_BITS) + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_e                 r_state, w_state_next;
    logic [SYNC_STAGES-1:0] r_start_sync, r_react_sync;
    logic                   r_start_prev, r_react_prev;
    logic                   w_start_pulse, w_react_pulse;
    logic [15:0]            w_lfsr;
    logic                   w_unused_lfsr;
    logic [TICK_W-1:0]      r_tick_cnt;
    logic                   w_tick;
    logic [DLY_W-1:0]       r_dly_cnt, w_dly_next, w_dly_load;
    logic [15:0]            r_bcd_cnt, w_bcd_next, w_bcd_out;
    logic                   r_timeout, w_timeout_next;
    logic                   r_stim_led, r_result_valid, r_false_start, r_busy;
    logic [15:0]            r_bcd_digits;

    // Buttons are asynchronous: synchronise, then keep only the rising edge.
    always_ff @(posedge clk) begin
        if (ck_rst) begin
            r_start_sync <= '0;
            r_react_sync <= '0;
            r_start_prev <= 1'b0;
            r_react_prev <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], btn_start};
            r_react_sync <= {r_react_sync[SYNC_STAGES-2:0], btn_react};
            r_start_prev <= r_start_sync[SYNC_STAGES-1];
            r_react_prev <= r_react_sync[SYNC_STAGES-1];
        end
    end

    assign w_start_pulse = r_start_sync[SYNC_STAGES-1] & ~r_start_prev;
    assign w_react_pulse = r_react_sync[SYNC_STAGES-1] & ~r_react_prev;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (clk),
        .i_rst   (ck_rst),
        .i_en    (1'b1),
        .o_state (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:DELAY_BITS];
    assign w_dly_load    = DLY_W'(MIN_DELAY_MS) + DLY_W'(w_lfsr[DELAY_BITS-1:0]);
    assign w_tick        = (r_tick_cnt == TICK_LAST);

    // Restarting on every transition makes the first tick land TICK_DIV cycles after entry.
    always_ff @(posedge clk) begin
        if (ck_rst || (w_state_next != r_state) || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_dly_next     = r_dly_cnt;
        w_bcd_next     = r_bcd_cnt;
        w_timeout_next = r_timeout;
        unique case (r_state)
            StIdle: begin
                if (w_start_pulse) begin
                    w_state_next = StDelay;
                    w_dly_next   = w_dly_load;
                end
            end
            StDelay: begin
                if (w_react_pulse) begin
                    w_state_next = StFault;
                end else if (w_tick) begin
                    if (r_dly_cnt < DLY_W'(2)) begin
                        w_state_next = StStim;
                        w_bcd_next   = 16'h0000;
                    end else begin
                        w_dly_next = r_dly_cnt - DLY_W'(1);
                    end
                end
            end
            StStim: begin
                if (w_react_pulse) begin
                    w_state_next = StResult;
                end else if (w_tick) begin
                    if (r_bcd_cnt == BCD_MAX) begin
                        w_state_next   = StResult;
                        w_timeout_next = 1'b1;
                    end else begin
                        w_bcd_next = bcd_inc(r_bcd_cnt);
                    end
                end
            end
            StResult, StFault: begin
                if (w_start_pulse) begin
                    w_state_next   = StDelay;
                    w_dly_next     = w_dly_load;
                    w_timeout_next = 1'b0;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        w_bcd_out = 16'h0000;
        case (w_state_next)
            StStim, StResult: w_bcd_out = w_bcd_next;
            StFault:          w_bcd_out = FAULT_CODE;
            default:          w_bcd_out = 16'h0000;
        endcase
    end

    // Outputs follow the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (ck_rst) begin
            r_state        <= StIdle;
            r_dly_cnt      <= '0;
            r_bcd_cnt      <= 16'h0000;
            r_timeout      <= 1'b0;
            r_stim_led     <= 1'b0;
            r_result_valid <= 1'b0;
            r_false_start  <= 1'b0;
            r_busy         <= 1'b0;
            r_bcd_digits   <= 16'h0000;
        end else begin
            r_state        <= w_state_next;
            r_dly_cnt      <= w_dly_next;
            r_bcd_cnt      <= w_bcd_next;
            r_timeout      <= w_timeout_next;
            r_stim_led     <= (w_state_next == StStim);
            r_result_valid <= (w_state_next == StResult);
            r_false_start  <= (w_state_next == StFault);
            r_busy         <= (w_state_next == StDelay) || (w_state_next == StStim);
            r_bcd_digits   <= w_bcd_out;
        end
    end

    assign stim_led     = r_stim_led;
    assign bcd_digits   = r_bcd_digits;
    assign result_valid = r_result_valid;
    assign false_start  = r_false_start;
    assign timeout      = r_timeout;
    assign busy         = r_busy;

endmodule
